mac_lut_lookup_arbiter: RTL and testbench



---
 rtl/mac_lut_arb_pkg.sv | 25 ++
 rtl/lookup_rr_arbiter.sv | 33 +++
 rtl/mac_lut_lookup_arbiter.sv | 173 +++++++++++++++++
 tb/tb_mac_lut_lookup_arbiter.sv | 531 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_lut_arb_pkg.sv
// Shared definitions for the MAC LUT lookup arbiter: FSM encodings, release
// hold-off length and a constant-evaluable clog2.
package mac_lut_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    localparam int RELEASE_MIN_CYCLES = 4;

    // Bits needed to hold 0..value-1 (1 for value <= 2).
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/lookup_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last served
// requester and wraps, returning the winner as one-hot and as an index.
module lookup_rr_arbiter
    import mac_lut_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        cand         = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found              = 1'b1;
                grant_idx          = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_lut_lookup_arbiter.sv
// Shares the MAC LUT lookup port among NUM_REQ header parsers with
// round-robin fairness, a four-phase LUT handshake and a stall watchdog.
module mac_lut_lookup_arbiter
    import mac_lut_arb_pkg::*;
#(
    parameter int                           NUM_REQ                   = 4,
    parameter int                           NUM_OUTPUT_QUEUES         = 8,
    parameter int                           NUM_IQ_BITS               = 3,
    parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 8'h55,
    parameter int                           TIMEOUT_CYCLES            = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*48-1:0]          req_dst_mac,
    input  logic [NUM_REQ*48-1:0]          req_src_mac,
    input  logic [NUM_REQ*NUM_IQ_BITS-1:0] req_src_port,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_OUTPUT_QUEUES-1:0]   rsp_dst_ports,
    output logic                           rsp_hit,
    output logic                           rsp_timeout,
    output logic [47:0]                    lut_dst_mac,
    output logic [47:0]                    lut_src_mac,
    output logic [NUM_IQ_BITS-1:0]         lut_src_port,
    output logic                           lut_lookup_req,
    input  logic [NUM_OUTPUT_QUEUES-1:0]   lut_dst_ports,
    input  logic                           lut_lookup_ack,
    input  logic                           lut_hit,
    input  logic                           lut_miss,
    output logic [31:0]                    timeout_count,
    output arb_state_t                     dbg_state
);

    // Handshakes: requesters hold req_valid as a level until the one-cycle
    // req_ack that carries their result; toward the LUT, lookup_req rises with
    // stable lut_* fields, stays high until lookup_ack is seen, and a new
    // request waits until the LUT has dropped ack again.

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int WD_W  = clog2(TIMEOUT_CYCLES);
    localparam int REL_W = clog2(RELEASE_MIN_CYCLES + 1);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_MIN_CYCLES - 1);

    arb_state_t state, state_next;

    logic [IDX_W-1:0]             last_grant;
    logic [IDX_W-1:0]             winner_idx;
    logic [NUM_REQ-1:0]           winner_oh;
    logic [WD_W-1:0]              watchdog;
    logic [REL_W-1:0]             rel_cnt;
    logic [NUM_REQ-1:0]           grant_onehot;
    logic [IDX_W-1:0]             grant_idx;
    logic                         take_grant;
    logic                         take_ack;
    logic                         take_timeout;
    logic [NUM_OUTPUT_QUEUES-1:0] src_bit;

    lookup_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_valid    (req_valid),
        .last_grant   (last_grant),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    assign src_bit   = NUM_OUTPUT_QUEUES'(1) << lut_src_port;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A same-edge ack beats watchdog expiry, so a slow but live LUT still
    // produces a real answer.
    always_comb begin
        state_next   = state;
        take_grant   = 1'b0;
        take_ack     = 1'b0;
        take_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|grant_onehot) begin
                    take_grant = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (lut_lookup_ack) begin
                    take_ack   = 1'b1;
                    state_next = ST_RELEASE;
                end else if (watchdog == WD_LAST) begin
                    take_timeout = 1'b1;
                    state_next   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (rel_cnt >= REL_LAST && !lut_lookup_ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ack        <= '0;
            rsp_dst_ports  <= '0;
            rsp_hit        <= 1'b0;
            rsp_timeout    <= 1'b0;
            lut_dst_mac    <= '0;
            lut_src_mac    <= '0;
            lut_src_port   <= '0;
            lut_lookup_req <= 1'b0;
            timeout_count  <= '0;
            last_grant     <= IDX_W'(NUM_REQ - 1);
            winner_idx     <= '0;
            winner_oh      <= '0;
            watchdog       <= '0;
            rel_cnt        <= '0;
        end else begin
            req_ack <= '0;

            if (take_grant) begin
                lut_dst_mac    <= req_dst_mac[int'(grant_idx)*48 +: 48];
                lut_src_mac    <= req_src_mac[int'(grant_idx)*48 +: 48];
                lut_src_port   <= req_src_port[int'(grant_idx)*NUM_IQ_BITS +: NUM_IQ_BITS];
                winner_idx     <= grant_idx;
                winner_oh      <= grant_onehot;
                watchdog       <= '0;
                lut_lookup_req <= 1'b1;
            end

            if (state == ST_REQ && !take_ack && !take_timeout) begin
                watchdog <= watchdog + WD_W'(1);
            end

            if (take_ack) begin
                rsp_dst_ports <= lut_dst_ports;
                // The LUT never raises hit and miss together.
                rsp_hit       <= lut_hit && !lut_miss;
                rsp_timeout   <= 1'b0;
            end

            if (take_timeout) begin
                rsp_dst_ports <= DEFAULT_MISS_OUTPUT_PORTS & ~src_bit;
                rsp_hit       <= 1'b0;
                rsp_timeout   <= 1'b1;
                if (timeout_count != '1) begin
                    timeout_count <= timeout_count + 32'd1;
                end
            end

            if (take_ack || take_timeout) begin
                req_ack        <= winner_oh;
                lut_lookup_req <= 1'b0;
                last_grant     <= winner_idx;
                rel_cnt        <= '0;
            end else if (state == ST_RELEASE && rel_cnt < REL_LAST) begin
                rel_cnt <= rel_cnt + REL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_lut_lookup_arbiter.sv
// Scenario bench for mac_lut_lookup_arbiter: a scripted LUT on the lookup
// side and a round-robin/watchdog reference model predicting each response.
module tb_mac_lut_lookup_arbiter;
    import mac_lut_arb_pkg::*;

    localparam int         NUM_REQ  = 4;
    localparam int         NQ       = 8;
    localparam int         NIQ      = 3;
    localparam int         TIMEOUT  = 1024;
    localparam logic [7:0] DEF_MISS = 8'h55;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NUM_REQ-1:0]     req_valid = '0;
    logic [NUM_REQ*48-1:0]  req_dst_mac = '0;
    logic [NUM_REQ*48-1:0]  req_src_mac = '0;
    logic [NUM_REQ*NIQ-1:0] req_src_port = '0;
    logic [NUM_REQ-1:0]     req_ack;
    logic [NQ-1:0]          rsp_dst_ports;
    logic                   rsp_hit;
    logic                   rsp_timeout;
    logic [47:0]            lut_dst_mac;
    logic [47:0]            lut_src_mac;
    logic [NIQ-1:0]         lut_src_port;
    logic                   lut_lookup_req;
    logic [NQ-1:0]          lut_dst_ports = '0;
    logic                   lut_lookup_ack = 1'b0;
    logic                   lut_hit = 1'b0;
    logic                   lut_miss = 1'b0;
    logic [31:0]            timeout_count;
    arb_state_t             dbg_state;

    mac_lut_lookup_arbiter #(
        .NUM_REQ                   (NUM_REQ),
        .NUM_OUTPUT_QUEUES         (NQ),
        .NUM_IQ_BITS               (NIQ),
        .DEFAULT_MISS_OUTPUT_PORTS (DEF_MISS),
        .TIMEOUT_CYCLES            (TIMEOUT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_dst_mac    (req_dst_mac),
        .req_src_mac    (req_src_mac),
        .req_src_port   (req_src_port),
        .req_ack        (req_ack),
        .rsp_dst_ports  (rsp_dst_ports),
        .rsp_hit        (rsp_hit),
        .rsp_timeout    (rsp_timeout),
        .lut_dst_mac    (lut_dst_mac),
        .lut_src_mac    (lut_src_mac),
        .lut_src_port   (lut_src_port),
        .lut_lookup_req (lut_lookup_req),
        .lut_dst_ports  (lut_dst_ports),
        .lut_lookup_ack (lut_lookup_ack),
        .lut_hit        (lut_hit),
        .lut_miss       (lut_miss),
        .timeout_count  (timeout_count),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // ---------------- reference model state ----------------
    int          model_last;
    int          model_timeouts;
    logic [47:0] dmac[NUM_REQ];
    logic [47:0] smac[NUM_REQ];
    logic [NIQ-1:0] sport[NUM_REQ];
    // {req_ack, rsp_dst_ports, rsp_hit, rsp_timeout}
    logic [NUM_REQ+NQ+1:0] exp_q[$];

    function automatic int model_pick(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            int c;
            c = (model_last + k) % NUM_REQ;
            if (v[c]) return c;
        end
        return 0;
    endfunction

    function automatic logic [7:0] model_timeout_ports(input logic [NIQ-1:0] sp);
        logic [7:0] p;
        p = DEF_MISS;
        p[sp] = 1'b0;
        return p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_reset();
        reset = 1'b1;
        req_valid = '0;
        lut_lookup_ack = 1'b0;
        lut_hit = 1'b0;
        lut_miss = 1'b0;
        lut_dst_ports = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_last = NUM_REQ - 1;
        model_timeouts = 0;
        exp_q.delete();
    endtask

    task automatic load_req_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            dmac[i]  = {16'($urandom), 32'($urandom)};
            smac[i]  = {16'($urandom), 32'($urandom)};
            sport[i] = NIQ'($urandom_range(0, 7));
        end
    endtask

    task automatic flatten_req_data();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_dst_mac[i*48 +: 48]   = dmac[i];
            req_src_mac[i*48 +: 48]   = smac[i];
            req_src_port[i*NIQ +: NIQ] = sport[i];
        end
    endtask

    task automatic lut_wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (lut_lookup_req) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Raise ack `delay` cycles from now; returns just after the sampling edge.
    task automatic lut_ack(input int delay, input logic [7:0] ports, input logic hit);
        repeat (delay) begin
            @(posedge clk);
            #1;
        end
        lut_lookup_ack = 1'b1;
        lut_dst_ports  = ports;
        lut_hit        = hit;
        lut_miss       = !hit;
        @(posedge clk);
        #1;
        lut_hit  = 1'b0;
        lut_miss = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        compared++;
        if ({req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== '0) begin
            mismatched++;
            $display("FAIL reset_rsp: got ack=%b ports=%h hit=%b to=%b want all 0",
                     req_ack, rsp_dst_ports, rsp_hit, rsp_timeout);
        end
        compared++;
        if ({lut_dst_mac, lut_src_mac, lut_src_port, lut_lookup_req} !== '0) begin
            mismatched++;
            $display("FAIL reset_lut: got dst=%h src=%h port=%0d req=%b want all 0",
                     lut_dst_mac, lut_src_mac, lut_src_port, lut_lookup_req);
        end
        compared++;
        if (timeout_count !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_count: got %0d want 0", timeout_count);
        end
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (lut_lookup_req !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_no_req: got %b want 0", lut_lookup_req);
        end
    endtask

    task automatic test_single();
        int pick;
        bit seen;
        logic [NUM_REQ+NQ+1:0] exp;
        load_req_data();
        dmac[2] = 48'h0011_2233_4455;
        flatten_req_data();
        req_valid = 4'b0100;
        pick = model_pick(req_valid);
        exp_q.push_back({NUM_REQ'(1) << pick, 8'h04, 1'b1, 1'b0});
        lut_wait_req(seen);
        compared++;
        if (!seen) begin
            mismatched++;
            $display("FAIL single_req: got no lut_lookup_req want one within 64 cycles");
        end
        compared++;
        if ({lut_dst_mac, lut_src_mac, lut_src_port} !== {dmac[pick], smac[pick], sport[pick]}) begin
            mismatched++;
            $display("FAIL single_fields: got dst=%h port=%0d want dst=%h port=%0d",
                     lut_dst_mac, lut_src_port, dmac[pick], sport[pick]);
        end
        lut_ack(3, 8'h04, 1'b1);
        req_valid = '0;
        model_last = pick;
        exp = exp_q.pop_front();
        compared++;
        if ({req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
            mismatched++;
            $display("FAIL single_rsp: got %b_%h_%b_%b want %h",
                     req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
        end
        compared++;
        if (lut_lookup_req !== 1'b0) begin
            mismatched++;
            $display("FAIL single_req_drop: got %b want 0", lut_lookup_req);
        end
        lut_lookup_ack = 1'b0;
        @(posedge clk);
        #1;
        compared++;
        if (req_ack !== '0) begin
            mismatched++;
            $display("FAIL single_ack_pulse: got %b want 0000", req_ack);
        end
    endtask

    task automatic test_fairness();
        int pick;
        bit seen;
        logic [7:0] ports;
        logic hit;
        logic [NUM_REQ+NQ+1:0] exp;
        apply_reset();
        load_req_data();
        flatten_req_data();
        req_valid = '1;
        for (int n = 0; n < 8; n++) begin
            pick  = model_pick(req_valid);
            ports = 8'($urandom);
            hit   = 1'($urandom_range(0, 1));
            exp_q.push_back({NUM_REQ'(1) << pick, ports, hit, 1'b0});
            lut_wait_req(seen);
            compared++;
            if (!seen || {lut_dst_mac, lut_src_mac, lut_src_port} !== {dmac[pick], smac[pick], sport[pick]}) begin
                mismatched++;
                $display("FAIL fair_grant%0d: got seen=%b src_mac=%h want src_mac=%h (req %0d)",
                         n, seen, lut_src_mac, smac[pick], pick);
            end
            lut_ack($urandom_range(0, 4), ports, hit);
            model_last = pick;
            exp = exp_q.pop_front();
            compared++;
            if ({req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
                mismatched++;
                $display("FAIL fair_rsp%0d: got %b_%h_%b_%b want %h",
                         n, req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
            end
            lut_lookup_ack = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_random();
        int pick;
        bit seen;
        logic [7:0] ports;
        logic hit;
        logic [NUM_REQ+NQ+1:0] exp;
        for (int n = 0; n < 12; n++) begin
            load_req_data();
            flatten_req_data();
            req_valid = NUM_REQ'($urandom_range(1, 15));
            pick  = model_pick(req_valid);
            ports = 8'($urandom);
            hit   = 1'($urandom_range(0, 1));
            exp_q.push_back({NUM_REQ'(1) << pick, ports, hit, 1'b0});
            lut_wait_req(seen);
            compared++;
            if (!seen || {lut_dst_mac, lut_src_mac, lut_src_port} !== {dmac[pick], smac[pick], sport[pick]}) begin
                mismatched++;
                $display("FAIL rand_grant%0d: got seen=%b dst=%h want dst=%h (req %0d)",
                         n, seen, lut_dst_mac, dmac[pick], pick);
            end
            // A granted requester losing interest must not abort the lookup.
            if ($urandom_range(0, 1) == 1) req_valid = '0;
            lut_ack($urandom_range(0, 6), ports, hit);
            model_last = pick;
            exp = exp_q.pop_front();
            compared++;
            if ({req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
                mismatched++;
                $display("FAIL rand_rsp%0d: got %b_%h_%b_%b want %h",
                         n, req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
            end
            lut_lookup_ack = 1'b0;
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        int pick;
        int cycles;
        bit seen;
        logic [NUM_REQ+NQ+1:0] exp;
        load_req_data();
        sport[1] = 3'd2;
        flatten_req_data();
        req_valid = 4'b0010;
        pick = model_pick(req_valid);
        exp_q.push_back({NUM_REQ'(1) << pick, model_timeout_ports(sport[pick]), 1'b0, 1'b1});
        lut_wait_req(seen);
        cycles = 0;
        while (req_ack == '0 && cycles < TIMEOUT + 80) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        req_valid = '0;
        model_last = pick;
        model_timeouts++;
        compared++;
        if (!seen || cycles != TIMEOUT) begin
            mismatched++;
            $display("FAIL timeout_latency: got %0d cycles (req seen=%b) want %0d", cycles, seen, TIMEOUT);
        end
        exp = exp_q.pop_front();
        compared++;
        if ({req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
            mismatched++;
            $display("FAIL timeout_rsp: got %b_%h_%b_%b want %h",
                     req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
        end
        compared++;
        if (timeout_count !== 32'(model_timeouts)) begin
            mismatched++;
            $display("FAIL timeout_count: got %0d want %0d", timeout_count, model_timeouts);
        end
    endtask

    task automatic test_late_ack();
        int pick;
        int cycles;
        int extra_acks;
        int req_seen;
        bit seen;
        logic [7:0] ports;
        logic hit;
        logic [NUM_REQ+NQ+1:0] exp;
        load_req_data();
        flatten_req_data();
        req_valid = 4'b0001;
        pick = model_pick(req_valid);
        exp_q.push_back({NUM_REQ'(1) << pick, model_timeout_ports(sport[pick]), 1'b0, 1'b1});
        lut_wait_req(seen);
        cycles = 0;
        while (req_ack == '0 && cycles < TIMEOUT + 80) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        req_valid = 4'b1000;
        model_last = pick;
        model_timeouts++;
        exp = exp_q.pop_front();
        compared++;
        if (!seen || {req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
            mismatched++;
            $display("FAIL late_forced_rsp: got %b_%h_%b_%b want %h",
                     req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
        end
        // LUT answers one cycle too late and keeps ack up for a while.
        lut_lookup_ack = 1'b1;
        lut_dst_ports  = 8'hff;
        extra_acks = 0;
        req_seen   = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (req_ack != '0) extra_acks++;
            if (lut_lookup_req) req_seen++;
        end
        compared++;
        if (extra_acks != 0 || req_seen != 0) begin
            mismatched++;
            $display("FAIL late_absorb: got %0d extra acks, %0d req cycles want 0 and 0", extra_acks, req_seen);
        end
        lut_lookup_ack = 1'b0;
        cycles = 0;
        while (!lut_lookup_req && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        compared++;
        if (cycles != 2) begin
            mismatched++;
            $display("FAIL late_regrant: got %0d cycles after ack drop want 2", cycles);
        end
        pick  = model_pick(req_valid);
        ports = 8'($urandom);
        hit   = 1'($urandom_range(0, 1));
        exp_q.push_back({NUM_REQ'(1) << pick, ports, hit, 1'b0});
        compared++;
        if (lut_src_mac !== smac[pick]) begin
            mismatched++;
            $display("FAIL late_next_fields: got %h want %h", lut_src_mac, smac[pick]);
        end
        lut_ack(1, ports, hit);
        req_valid = '0;
        model_last = pick;
        exp = exp_q.pop_front();
        compared++;
        if ({req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
            mismatched++;
            $display("FAIL late_next_rsp: got %b_%h_%b_%b want %h",
                     req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
        end
        lut_lookup_ack = 1'b0;
    endtask

    task automatic test_coincident();
        int pick;
        bit seen;
        logic [7:0] ports;
        logic hit;
        logic [NUM_REQ+NQ+1:0] exp;
        load_req_data();
        flatten_req_data();
        req_valid = 4'b0001;
        pick  = model_pick(req_valid);
        ports = 8'($urandom);
        hit   = 1'($urandom_range(0, 1));
        exp_q.push_back({NUM_REQ'(1) << pick, ports, hit, 1'b0});
        lut_wait_req(seen);
        lut_ack(TIMEOUT - 1, ports, hit);
        req_valid = '0;
        model_last = pick;
        exp = exp_q.pop_front();
        compared++;
        if (!seen || {req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
            mismatched++;
            $display("FAIL coinc_rsp: got %b_%h_%b_%b want %h",
                     req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
        end
        compared++;
        if (timeout_count !== 32'(model_timeouts)) begin
            mismatched++;
            $display("FAIL coinc_count: got %0d want %0d", timeout_count, model_timeouts);
        end
        lut_lookup_ack = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        int pick;
        bit seen;
        logic [7:0] ports;
        logic [NUM_REQ+NQ+1:0] exp;
        load_req_data();
        flatten_req_data();
        req_valid = 4'b0100;
        lut_wait_req(seen);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (!seen || lut_lookup_req !== 1'b0 || dbg_state !== ST_IDLE) begin
            mismatched++;
            $display("FAIL rst_async: got req=%b state=%0d (seen=%b) want req=0 state=0",
                     lut_lookup_req, dbg_state, seen);
        end
        @(posedge clk);
        #1;
        compared++;
        if (req_ack !== '0) begin
            mismatched++;
            $display("FAIL rst_no_ack: got %b want 0000", req_ack);
        end
        reset = 1'b0;
        model_last = NUM_REQ - 1;
        model_timeouts = 0;
        exp_q.delete();
        req_valid = '1;
        pick  = model_pick(req_valid);
        ports = 8'($urandom);
        exp_q.push_back({NUM_REQ'(1) << pick, ports, 1'b1, 1'b0});
        lut_wait_req(seen);
        compared++;
        if (!seen || {lut_src_mac, lut_src_port} !== {smac[pick], sport[pick]}) begin
            mismatched++;
            $display("FAIL rst_first_grant: got src=%h want src=%h (req %0d)", lut_src_mac, smac[pick], pick);
        end
        lut_ack(2, ports, 1'b1);
        req_valid = '0;
        model_last = pick;
        exp = exp_q.pop_front();
        compared++;
        if ({req_ack, rsp_dst_ports, rsp_hit, rsp_timeout} !== exp) begin
            mismatched++;
            $display("FAIL rst_first_rsp: got %b_%h_%b_%b want %h",
                     req_ack, rsp_dst_ports, rsp_hit, rsp_timeout, exp);
        end
        compared++;
        if (timeout_count !== 32'd0) begin
            mismatched++;
            $display("FAIL rst_count: got %0d want 0", timeout_count);
        end
        lut_lookup_ack = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_random();
        test_timeout();
        test_late_ack();
        test_coincident();
        test_reset_mid_req();
        repeat (8) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
